// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with the result sign applied on the edge that enters DONE.
module muldiv_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid_i,
   input  logic            mul_en_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic            rs1_sign_i,
   input  logic            rs2_sign_i,
   input  logic            word_i,
   input  logic            flush_i,
   output logic            req_ready_o,
   output logic            resp_valid_o,
   output logic            stall_o,
   output logic [XLEN-1:0] data_1_o,
   output logic [XLEN-1:0] data_2_o
);

   localparam int HW = XLEN / 2;
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [2*XLEN-1:0]   acc;
   logic [2*XLEN-1:0]   mcand;   // multiplicand (shifts left); low half is the divisor in DIV
   logic [XLEN-1:0]     mplier;  // multiplier (shifts right) or dividend (shifts left)
   logic [XLEN-1:0]     rem;
   logic [XLEN-1:0]     quo;
   logic                neg_res;
   logic                neg_a;
   logic                word_q;

   function automatic logic [XLEN-1:0] sext_h(input logic [HW-1:0] v);
      return {{(XLEN-HW){v[HW-1]}}, v};
   endfunction

   // Operand selection and magnitude conversion
   logic [XLEN-1:0] op_a, op_b, mag_a, mag_b;
   logic            sgn_a, sgn_b;

   always_comb begin
      op_a = rs1_data_i;
      op_b = rs2_data_i;
      if (word_i) begin
         op_a = rs1_sign_i ? sext_h(rs1_data_i[HW-1:0]) : {{(XLEN-HW){1'b0}}, rs1_data_i[HW-1:0]};
         op_b = rs2_sign_i ? sext_h(rs2_data_i[HW-1:0]) : {{(XLEN-HW){1'b0}}, rs2_data_i[HW-1:0]};
      end
      sgn_a = rs1_sign_i & op_a[XLEN-1];
      sgn_b = rs2_sign_i & op_b[XLEN-1];
      mag_a = sgn_a ? -op_a : op_a;
      mag_b = sgn_b ? -op_b : op_b;
   end

   // One iteration step, plus the sign-fixed results used on the final step
   logic [2*XLEN-1:0] acc_nx, prod;
   logic [XLEN:0]     trial;
   logic              qbit;
   logic [XLEN-1:0]   rem_nx, quo_nx, q_fix, r_fix;
   logic              last;

   always_comb begin
      acc_nx = mplier[0] ? acc + mcand : acc;
      trial  = {rem, mplier[XLEN-1]};
      qbit   = trial >= {1'b0, mcand[XLEN-1:0]};
      rem_nx = qbit ? trial[XLEN-1:0] - mcand[XLEN-1:0] : trial[XLEN-1:0];
      quo_nx = {quo[XLEN-2:0], qbit};
      prod   = neg_res ? -acc_nx : acc_nx;
      q_fix  = neg_res ? -quo_nx : quo_nx;
      r_fix  = neg_a ? -rem_nx : rem_nx;
      last   = cnt == (word_q ? CW'(HW-1) : CW'(XLEN-1));
   end

   assign req_ready_o = (state == IDLE);
   assign stall_o     = req_valid_i & ~resp_valid_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         acc          <= '0;
         mcand        <= '0;
         mplier       <= '0;
         rem          <= '0;
         quo          <= '0;
         neg_res      <= 1'b0;
         neg_a        <= 1'b0;
         word_q       <= 1'b0;
         resp_valid_o <= 1'b0;
         data_1_o     <= '0;
         data_2_o     <= '0;
      end else begin
         resp_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid_i && !flush_i) begin
                  cnt     <= '0;
                  acc     <= '0;
                  rem     <= '0;
                  quo     <= '0;
                  word_q  <= word_i;
                  neg_res <= sgn_a ^ sgn_b;
                  neg_a   <= sgn_a;
                  mcand   <= {{XLEN{1'b0}}, mag_b};
                  // word divide: park the dividend at the top so bits leave MSB-first
                  mplier  <= (!mul_en_i && word_i) ? (mag_a << HW) : mag_a;
                  if (mul_en_i) begin
                     state <= MUL;
                  end else if (op_b == '0) begin
                     state        <= DONE;
                     resp_valid_o <= 1'b1;
                     data_1_o     <= '1;
                     data_2_o     <= word_i ? sext_h(op_a[HW-1:0]) : op_a;
                  end else begin
                     state <= DIV;
                  end
               end
            end
            MUL: begin
               if (flush_i) begin
                  state <= IDLE;
               end else begin
                  acc    <= acc_nx;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + CW'(1);
                  if (last) begin
                     state        <= DONE;
                     resp_valid_o <= 1'b1;
                     data_1_o     <= word_q ? sext_h(prod[HW-1:0]) : prod[XLEN-1:0];
                     data_2_o     <= word_q ? sext_h(prod[XLEN-1:HW]) : prod[2*XLEN-1:XLEN];
                  end
               end
            end
            DIV: begin
               if (flush_i) begin
                  state <= IDLE;
               end else begin
                  rem    <= rem_nx;
                  quo    <= quo_nx;
                  mplier <= mplier << 1;
                  cnt    <= cnt + CW'(1);
                  if (last) begin
                     state        <= DONE;
                     resp_valid_o <= 1'b1;
                     data_1_o     <= word_q ? sext_h(q_fix[HW-1:0]) : q_fix;
                     data_2_o     <= word_q ? sext_h(r_fix[HW-1:0]) : r_fix;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
